// File: rtl/gpr_wb_arbiter.sv
// Round-robin writeback arbiter between the ALU and the LSU for the single register-file
// write port, with a per-register pending-write scoreboard that feeds decode's RAW status.
module gpr_wb_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_full,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              pend_err
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_R0  = {ADDR_W{1'b0}};

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;

  grant_e                      last_grant_r;
  logic [NREG-1:0][PEND_W-1:0] cnt_r;
  logic                        xfer_s;
  logic [ADDR_W-1:0]           xfer_addr_s;
  logic [DATA_W-1:0]           xfer_data_s;
  logic                        issue_inc_s;
  logic [NREG-1:0]             inc_vec_s;
  logic [NREG-1:0]             dec_vec_s;

  // Round-robin grant: on a tie the requester that did not win last time goes first
  always_comb begin
    alu_ready   = 1'b0;
    lsu_ready   = 1'b0;
    xfer_s      = 1'b0;
    xfer_addr_s = ADDR_R0;
    xfer_data_s = {DATA_W{1'b0}};
    if (alu_valid && (!lsu_valid || (last_grant_r == GRANT_LSU))) begin
      alu_ready   = 1'b1;
      xfer_s      = 1'b1;
      xfer_addr_s = alu_addr;
      xfer_data_s = alu_data;
    end else if (lsu_valid) begin
      lsu_ready   = 1'b1;
      xfer_s      = 1'b1;
      xfer_addr_s = lsu_addr;
      xfer_data_s = lsu_data;
    end else begin
      xfer_s = 1'b0;
    end
  end

  // Scoreboard status and one-hot issue/commit strobes; r0 never tracks anything
  always_comb begin
    issue_full  = (issue_addr != ADDR_R0) && (cnt_r[issue_addr] == CNT_MAX);
    issue_inc_s = issue_en && (issue_addr != ADDR_R0) && !issue_full;
    rs_busy     = (cnt_r[rs_addr] != CNT_ZERO);
    rt_busy     = (cnt_r[rt_addr] != CNT_ZERO);
    if (issue_inc_s) begin
      inc_vec_s = NREG'(1) << issue_addr;
    end else begin
      inc_vec_s = {NREG{1'b0}};
    end
    if (xfer_s && (xfer_addr_s != ADDR_R0)) begin
      dec_vec_s = NREG'(1) << xfer_addr_s;
    end else begin
      dec_vec_s = {NREG{1'b0}};
    end
  end

  // Pending-write counters; underflow saturates at zero and latches the sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {(NREG*PEND_W){1'b0}};
      pend_err <= 1'b0;
    end else begin
      cnt_r[0] <= CNT_ZERO;
      for (int i = 1; i < NREG; i++) begin
        case ({inc_vec_s[i], dec_vec_s[i]})
          2'b10: cnt_r[i] <= cnt_r[i] + PEND_W'(1);
          2'b01: begin
            if (cnt_r[i] == CNT_ZERO) begin
              pend_err <= 1'b1;
            end else begin
              cnt_r[i] <= cnt_r[i] - PEND_W'(1);
            end
          end
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Registered write port and arbitration history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en     <= 1'b0;
      write_addr   <= ADDR_R0;
      write_data   <= {DATA_W{1'b0}};
      last_grant_r <= GRANT_LSU;
    end else begin
      write_en <= xfer_s && (xfer_addr_s != ADDR_R0);
      if (xfer_s) begin
        last_grant_r <= alu_ready ? GRANT_ALU : GRANT_LSU;
        if (xfer_addr_s != ADDR_R0) begin
          write_addr <= xfer_addr_s;
          write_data <= xfer_data_s;
        end
      end
    end
  end

endmodule
